keypad_scanner: RTL and testbench

Drives the columns of a 4x4 matrix keypad one at a time, samples the active-low rows, debounces, and emits the 6-bit key code `{col[1:0], row_n[3:0]}` consumed by the keypad encoder. It is the front end of the keypad controller. It turns raw pin activity into one clean, single-cycle event per key press and tracks key-hold state until release.

---
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning front end for a 4x4 active-low matrix keypad.
// Drives one column at a time, synchronises and debounces the rows, and emits
// a single-cycle key_valid per accepted press plus a key_held level.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [5:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       rs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [DB_W-1:0]  match_q;
  logic [DB_W-1:0]  match_d;
  logic [DB_W-1:0]  rel_q;
  logic [DB_W-1:0]  rel_d;
  logic [1:0]       col_idx_q;
  logic [3:0]       col_n_q;
  logic [3:0]       cand_rows_q;
  logic [1:0]       cand_col_q;
  logic [5:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic             sample_c;
  logic             valid_pat_c;

  // Sample point, single-key pattern check and counter increments.
  always_comb begin
    sample_c    = (cnt_q == CNT_LAST);
    valid_pat_c = $onehot(~rs_q);
    cnt_d       = sample_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    match_d     = DB_W'(match_q + DB_W'(1));
    rel_d       = DB_W'(rel_q + DB_W'(1));
  end

  // Two-flop row synchroniser; idle value is all rows high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      rs_q    <= 4'b1111;
    end else begin
      sync1_q <= row_n;
      rs_q    <= sync1_q;
    end
  end

  // Free-running dwell counter, wraps every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Scan / debounce / hold state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      match_q     <= '0;
      rel_q       <= '0;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      cand_rows_q <= 4'b1111;
      cand_col_q  <= 2'd0;
      key_code_q  <= 6'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (sample_c) begin
        case (state_q)
          ST_SCAN: begin
            if (valid_pat_c) begin
              cand_rows_q <= rs_q;
              cand_col_q  <= col_idx_q;
              match_q     <= '0;
              state_q     <= ST_DEBOUNCE;
            end else begin
              col_idx_q <= col_idx_q + 2'd1;
              col_n_q   <= {col_n_q[2:0], col_n_q[3]};
            end
          end
          ST_DEBOUNCE: begin
            if (rs_q == cand_rows_q) begin
              if (match_d == DB_TARGET) begin
                key_code_q  <= {cand_col_q, cand_rows_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_q       <= '0;
                state_q     <= ST_HELD;
              end else begin
                match_q <= match_d;
              end
            end else begin
              state_q   <= ST_SCAN;
              col_idx_q <= col_idx_q + 2'd1;
              col_n_q   <= {col_n_q[2:0], col_n_q[3]};
            end
          end
          ST_HELD: begin
            if (rs_q == 4'b1111) begin
              if (rel_d == DB_TARGET) begin
                key_held_q <= 1'b0;
                state_q    <= ST_SCAN;
                col_idx_q  <= col_idx_q + 2'd1;
                col_n_q    <= {col_n_q[2:0], col_n_q[3]};
              end else begin
                rel_q <= rel_d;
              end
            end else begin
              rel_q <= '0;
            end
          end
          default: begin
            state_q <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus scoreboard of expected key codes.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [5:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       press_en;
  logic       ghost_en;
  logic [1:0] kcol;
  logic [1:0] krow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  logic prev_valid = 1'b0;
  logic [5:0] sb[$];

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: pressed row pulled low only while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    if (press_en && (col_n[kcol] == 1'b0)) row_n[krow] = 1'b0;
    if (ghost_en && (col_n[0] == 1'b0)) row_n = 4'b1100;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] pat, input int max_cyc, input string tag);
    int n = 0;
    while ((col_n !== pat) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(col_n), 32'(pat));
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((key_valid !== 1'b1) && (n < max_cyc));
  endtask

  task automatic wait_release(input int max_cyc, input string tag);
    int n = 0;
    while ((key_held !== 1'b0) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_held), 32'd0);
  endtask

  // Scoreboard: every key_valid pulse pops and compares one expected code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_valid++;
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("key_code", 32'(key_code), 32'(sb.pop_front()));
      end
    end
    prev_valid = key_valid;
  end

  initial begin
    int n;
    int nv0;
    press_en = 1'b0;
    ghost_en = 1'b0;
    kcol     = 2'd0;
    krow     = 2'd0;
    rst      = 1'b0;
    #2 rst = 1'b1;

    // 1. Reset values and idle scan order.
    step(3);
    check("rst_col", 32'(col_n), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      logic [3:0] exp_col;
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / 8) % 4));
      check($sformatf("idle_col_%0d", i), 32'(col_n), 32'(exp_col));
    end

    // 2. Press column 2 row 1 and check press latency.
    kcol = 2'd2;
    krow = 2'd1;
    sb.push_back(6'b101101);
    press_en = 1'b1;
    wait_col(4'b1011, 40, "reach_col2");
    wait_valid(40, n);
    check("press_latency", 32'(n), 32'd24);
    step(1);
    check("valid_low", 32'(key_valid), 32'd0);
    check("held_high", 32'(key_held), 32'd1);
    check("held_col", 32'(col_n), 32'hB);

    // 4. Release: held falls at the second all-high sample; re-press once.
    step(1);
    press_en = 1'b0;
    step(13);
    check("held_before_rel", 32'(key_held), 32'd1);
    check("col_before_rel", 32'(col_n), 32'hB);
    step(1);
    check("held_after_rel", 32'(key_held), 32'd0);
    check("col_after_rel", 32'(col_n), 32'h7);
    check("code_kept", 32'(key_code), 32'h2D);
    sb.push_back(6'b101101);
    press_en = 1'b1;
    wait_valid(60, n);
    check("repress_latency", 32'(n), 32'd48);
    step(1);
    press_en = 1'b0;
    wait_release(60, "repress_release");

    // 3. Bounce: row low at exactly one sample point.
    wait_col(4'b1011, 60, "bounce_col2");
    nv0 = n_valid;
    step(3);
    press_en = 1'b1;
    step(6);
    press_en = 1'b0;
    step(3);
    check("bounce_frozen", 32'(col_n), 32'hB);
    step(3);
    check("bounce_col_15", 32'(col_n), 32'hB);
    step(1);
    check("bounce_resume", 32'(col_n), 32'h7);
    check("bounce_held", 32'(key_held), 32'd0);
    check("bounce_no_valid", 32'(n_valid), 32'(nv0));

    // 5. Ghosting on column 0 never detected.
    ghost_en = 1'b1;
    nv0 = n_valid;
    wait_col(4'b1110, 40, "ghost_col0");
    n = 0;
    while ((col_n === 4'b1110) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("ghost_dwell", 32'(n), 32'd8);
    check("ghost_next", 32'(col_n), 32'hD);
    step(64);
    check("ghost_held", 32'(key_held), 32'd0);
    check("ghost_no_valid", 32'(n_valid), 32'(nv0));
    ghost_en = 1'b0;

    // 6. Reset while held, then re-acceptance of the still-pressed key.
    kcol = 2'd1;
    krow = 2'd3;
    sb.push_back(6'b010111);
    press_en = 1'b1;
    wait_valid(100, n);
    check("held_press_seen", 32'(key_valid), 32'd1);
    step(3);
    check("pre_rst_held", 32'(key_held), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_held", 32'(key_held), 32'd0);
    check("async_code", 32'(key_code), 32'h0);
    check("async_col", 32'(col_n), 32'hE);
    check("async_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(6'b010111);
    wait_valid(100, n);
    check("reaccept_seen", 32'(key_valid), 32'd1);
    step(1);
    check("reaccept_held", 32'(key_held), 32'd1);
    press_en = 1'b0;
    wait_release(80, "final_release");

    step(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
